icb_arb2: RTL and testbench
===========================

ICB_ARB2 -- requirements
Module: icb_arb2

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waiting for a read response before an error response is synthesized (1..65535).
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports per master mN (N=0,1): mN_icb_cmd_valid in 1; mN_icb_cmd_ready out 1; mN_icb_cmd_addr in 32; mN_icb_cmd_read in 1; mN_icb_cmd_wdata in 32; mN_icb_cmd_wmask in 4.
REQ-005 Ports per master mN, response side: mN_icb_rsp_valid out 1; mN_icb_rsp_ready in 1; mN_icb_rsp_err out 1; mN_icb_rsp_rdata out 32.
REQ-006 Slave ports: s_icb_cmd_valid out 1; s_icb_cmd_ready in 1; s_icb_cmd_addr out 32; s_icb_cmd_read out 1; s_icb_cmd_wdata out 32; s_icb_cmd_wmask out 4; s_icb_rsp_valid in 1; s_icb_rsp_ready out 1; s_icb_rsp_err in 1; s_icb_rsp_rdata in 32.

Function
REQ-007 The block SHALL arbitrate two ICB masters onto one ICB slave (data SRAM port), one outstanding read at a time.
REQ-008 States SHALL be IDLE and RSP; cmd handshake = valid & ready on the same cycle.
REQ-009 In IDLE, winner SHALL be: the only requester if one; on contention the master not granted last (round-robin via last_grant bit).
REQ-010 In IDLE, winner's cmd fields SHALL drive the slave combinationally; s_icb_cmd_valid = winner valid; winner cmd_ready = s_icb_cmd_ready; loser cmd_ready = 0.
REQ-011 Write handshake (read=0): SHALL complete on the cmd handshake, produce no master response, stay IDLE, set last_grant = winner.
REQ-012 Read handshake (read=1): SHALL latch owner = winner, set last_grant = winner, clear timer, go to RSP next cycle.
REQ-013 In RSP, s_icb_cmd_valid and both mN_icb_cmd_ready SHALL be 0.
REQ-014 In RSP, owner's rsp_valid/err/rdata SHALL mirror the slave's; s_icb_rsp_ready = owner rsp_ready; non-owner rsp_valid = 0, rdata = 0, err = 0.
REQ-015 RSP SHALL return to IDLE on the cycle after s_icb_rsp_valid & owner rsp_ready; a new command SHALL be accepted no earlier than that IDLE cycle (min read-to-read spacing 2 cycles after response).
REQ-016 Timer SHALL increment each RSP cycle while s_icb_rsp_valid = 0; saturating 16-bit.
REQ-017 When timer reaches TIMEOUT with no slave response, block SHALL drive owner rsp_valid = 1, err = 1, rdata = 0 until owner rsp_ready, then go IDLE; a slave response arriving later SHALL be accepted (s_icb_rsp_ready = 1 in IDLE) and discarded.
REQ-018 s_icb_rsp_valid arriving in IDLE SHALL be dropped without reaching any master.
REQ-019 Requests held by a non-granted master SHALL remain pending, never lost; no master SHALL starve (at most one other grant between its request and its grant).

Reset
REQ-020 On rst: state = IDLE, last_grant = 1 (m0 wins first contention), owner = 0, timer = 0.
REQ-021 Outputs after reset SHALL be: all rsp_valid = 0, s_icb_cmd_valid = 0 unless a master requests, s_icb_rsp_ready = 1.
REQ-022 rst asserted in RSP SHALL abandon the outstanding read; no response delivered to the owner.

Structure
REQ-023 Address/data widths SHALL come from the shared defines include (MemAddrBus, MemBus); no new package constants.
REQ-024 A sub-module icb_rr_pick (2 requests + last_grant -> one-hot grant, combinational) SHALL implement REQ-009.

Verification
REQ-025 m0 read 0x2000_0010 alone, slave returns 0xDEADBEEF after 1 cycle -> m0 rsp_valid, rdata 0xDEADBEEF; m1 sees nothing.
REQ-026 m0 and m1 both write every cycle, s_cmd_ready = 1 -> grants alternate m0,m1,m0,m1 after reset.
REQ-027 m1 read outstanding, m0 asserts write -> m0 cmd_ready = 0 until m1 response accepted, then m0 write issued.
REQ-028 TIMEOUT = 4, slave never responds -> on 4th RSP cycle owner gets rsp_valid = 1, err = 1, rdata = 0; late slave response discarded.
REQ-029 rst pulsed during RSP -> state IDLE next cycle, no rsp_valid to owner, m0 wins next contention.
REQ-030 Slave holds rsp_valid, owner rsp_ready low 3 cycles -> rsp held stable, s_icb_rsp_ready low, no new grant.

Source files
------------

// File: rtl/icb_arb2_pkg.sv
// Shared types for the two-master ICB arbiter.
// The bus-width defines are guarded so that an SoC-wide defines file can
// supply them first; the arbiter takes its address/data widths from them.
`ifndef ICB_ARB2_MEM_DEFINES
`define ICB_ARB2_MEM_DEFINES
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif
`endif

package icb_arb2_pkg;

    // IDLE accepts commands; RSP waits for the single outstanding read
    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/icb_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins; on contention the
// master that was not granted last wins.
module icb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // one-hot winner, favouring the master not granted last on contention
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/icb_arb2.sv
// Arbitrates two ICB masters onto one ICB slave (data SRAM port) with a
// single outstanding read. Writes complete on the command handshake; reads
// hold the arbiter in RSP until the owner takes the response, or until a
// timeout synthesizes an error response.
module icb_arb2
    import icb_arb2_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               m0_icb_cmd_valid,
    output logic               m0_icb_cmd_ready,
    input  logic [`MemAddrBus] m0_icb_cmd_addr,
    input  logic               m0_icb_cmd_read,
    input  logic [`MemBus]     m0_icb_cmd_wdata,
    input  logic [3:0]         m0_icb_cmd_wmask,
    output logic               m0_icb_rsp_valid,
    input  logic               m0_icb_rsp_ready,
    output logic               m0_icb_rsp_err,
    output logic [`MemBus]     m0_icb_rsp_rdata,

    input  logic               m1_icb_cmd_valid,
    output logic               m1_icb_cmd_ready,
    input  logic [`MemAddrBus] m1_icb_cmd_addr,
    input  logic               m1_icb_cmd_read,
    input  logic [`MemBus]     m1_icb_cmd_wdata,
    input  logic [3:0]         m1_icb_cmd_wmask,
    output logic               m1_icb_rsp_valid,
    input  logic               m1_icb_rsp_ready,
    output logic               m1_icb_rsp_err,
    output logic [`MemBus]     m1_icb_rsp_rdata,

    output logic               s_icb_cmd_valid,
    input  logic               s_icb_cmd_ready,
    output logic [`MemAddrBus] s_icb_cmd_addr,
    output logic               s_icb_cmd_read,
    output logic [`MemBus]     s_icb_cmd_wdata,
    output logic [3:0]         s_icb_cmd_wmask,
    input  logic               s_icb_rsp_valid,
    output logic               s_icb_rsp_ready,
    input  logic               s_icb_rsp_err,
    input  logic [`MemBus]     s_icb_rsp_rdata
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
    localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);

    arb_state_t  state;
    logic        last_grant;
    logic        owner;
    logic [15:0] timer;

    logic [1:0]  grant;
    logic        win;
    logic        in_idle;
    logic        in_rsp;
    logic        cmd_hs;
    logic        timed_out;
    logic        owner_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [`MemBus] rsp_rdata;
    logic        rsp_done;
    logic        own0;
    logic        own1;

    icb_rr_pick u_pick (
        .req        ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win     = grant[1];
    assign in_idle = (state == IDLE);
    assign in_rsp  = (state == RSP);

    // Command path: the winner's fields go straight to the slave; a reset
    // cycle masks every handshake so nothing is half-accepted.
    assign s_icb_cmd_valid  = in_idle && (grant != 2'b00) && !rst;
    assign s_icb_cmd_addr   = win ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read   = win ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata  = win ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = win ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign m0_icb_cmd_ready = in_idle && grant[0] && s_icb_cmd_ready && !rst;
    assign m1_icb_cmd_ready = in_idle && grant[1] && s_icb_cmd_ready && !rst;
    assign cmd_hs           = s_icb_cmd_valid && s_icb_cmd_ready;

    // Timeout counts the current silent cycle too, so the error appears on
    // the TIMEOUT-th silent RSP cycle and stays up until the owner takes it.
    assign timed_out   = (timer >= TO_LIM) || ((timer == TO_M1) && !s_icb_rsp_valid);
    assign owner_ready = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    assign rsp_valid   = in_rsp && !rst && (timed_out || s_icb_rsp_valid);
    assign rsp_err     = timed_out ? 1'b1 : s_icb_rsp_err;
    assign rsp_rdata   = timed_out ? '0 : s_icb_rsp_rdata;
    assign rsp_done    = rsp_valid && owner_ready;

    // Outside RSP the slave response channel is always drained and dropped;
    // during an error response a late slave reply waits for IDLE.
    assign s_icb_rsp_ready = in_rsp ? (!timed_out && owner_ready) : 1'b1;

    assign own0 = in_rsp && !rst && !owner;
    assign own1 = in_rsp && !rst && owner;

    assign m0_icb_rsp_valid = own0 && rsp_valid;
    assign m0_icb_rsp_err   = own0 && rsp_err;
    assign m0_icb_rsp_rdata = own0 ? rsp_rdata : '0;
    assign m1_icb_rsp_valid = own1 && rsp_valid;
    assign m1_icb_rsp_err   = own1 && rsp_err;
    assign m1_icb_rsp_rdata = own1 ? rsp_rdata : '0;

    // Arbiter state: grant history, read ownership and response timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        last_grant <= win;
                        if (s_icb_cmd_read) begin
                            owner <= win;
                            timer <= '0;
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_done) begin
                        state <= IDLE;
                    end else if (!s_icb_rsp_valid && (timer != 16'hFFFF)) begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icb_arb2.sv
// Self-checking bench for icb_arb2: a transaction-level reference model is
// compared against every output on every cycle, with table vectors, directed
// corner-case sequences and a randomized phase layered on top.
module tb_icb_arb2;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
    logic [3:0]  m0_icb_cmd_wmask;
    logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [31:0] m0_icb_rsp_rdata;
    logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
    logic [3:0]  m1_icb_cmd_wmask;
    logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [31:0] m1_icb_rsp_rdata;
    logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [31:0] s_icb_rsp_rdata;

    int checks = 0;
    int errors = 0;

    // reference model: is a read outstanding, who owns it, who wins the
    // next contention, and how many silent response cycles have passed
    bit busy, n_busy;
    int owner, n_owner;
    int prio, n_prio;
    int waited, n_waited;

    icb_arb2 #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // compare all outputs with the model at the falling edge, then work out
    // the model's state after the coming rising edge
    task automatic eval();
        logic [1:0]  v, rd, cr, rv, re;
        logic [31:0] a[2], wd[2], rdat[2];
        logic [3:0]  wm[2];
        int win, silent;
        bit terr, oready, ev;
        @(negedge clk);
        v  = {m1_icb_cmd_valid, m0_icb_cmd_valid};
        rd = {m1_icb_cmd_read, m0_icb_cmd_read};
        cr = {m1_icb_cmd_ready, m0_icb_cmd_ready};
        rv = {m1_icb_rsp_valid, m0_icb_rsp_valid};
        re = {m1_icb_rsp_err, m0_icb_rsp_err};
        a[0] = m0_icb_cmd_addr;   a[1] = m1_icb_cmd_addr;
        wd[0] = m0_icb_cmd_wdata; wd[1] = m1_icb_cmd_wdata;
        wm[0] = m0_icb_cmd_wmask; wm[1] = m1_icb_cmd_wmask;
        rdat[0] = m0_icb_rsp_rdata; rdat[1] = m1_icb_rsp_rdata;
        n_busy = busy; n_owner = owner; n_prio = prio; n_waited = waited;
        if (rst) begin
            chk("rst s_cmd_valid", 32'(s_icb_cmd_valid), 0);
            chk("rst cmd_ready", 32'(cr), 0);
            chk("rst rsp_valid", 32'(rv), 0);
            n_busy = 0; n_owner = 0; n_prio = 0; n_waited = 0;
        end else if (!busy) begin
            win = (v == 2'b11) ? prio : (v[0] ? 0 : (v[1] ? 1 : -1));
            chk("s_cmd_valid", 32'(s_icb_cmd_valid), 32'(win >= 0));
            chk("m0_cmd_ready", 32'(cr[0]), 32'(win == 0 && s_icb_cmd_ready));
            chk("m1_cmd_ready", 32'(cr[1]), 32'(win == 1 && s_icb_cmd_ready));
            if (win >= 0) begin
                chk("s_cmd_addr", s_icb_cmd_addr, a[win]);
                chk("s_cmd_read", 32'(s_icb_cmd_read), 32'(rd[win]));
                chk("s_cmd_wdata", s_icb_cmd_wdata, wd[win]);
                chk("s_cmd_wmask", 32'(s_icb_cmd_wmask), 32'(wm[win]));
            end
            chk("idle rsp_valid", 32'(rv), 0);
            chk("idle s_rsp_ready", 32'(s_icb_rsp_ready), 1);
            if (win >= 0 && s_icb_cmd_ready) begin
                n_prio = 1 - win;
                if (rd[win]) begin
                    n_busy = 1; n_owner = win; n_waited = 0;
                end
            end
        end else begin
            silent = waited + (s_icb_rsp_valid ? 0 : 1);
            terr   = (silent >= TO);
            oready = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
            ev     = terr || s_icb_rsp_valid;
            chk("rsp s_cmd_valid", 32'(s_icb_cmd_valid), 0);
            chk("rsp cmd_ready", 32'(cr), 0);
            for (int m = 0; m < 2; m++) begin
                if (m == owner) begin
                    chk("owner rsp_valid", 32'(rv[m]), 32'(ev));
                    chk("owner rsp_err", 32'(re[m]), terr ? 1 : 32'(s_icb_rsp_err));
                    chk("owner rsp_rdata", rdat[m], terr ? 0 : s_icb_rsp_rdata);
                end else begin
                    chk("other rsp_valid", 32'(rv[m]), 0);
                    chk("other rsp_err", 32'(re[m]), 0);
                    chk("other rsp_rdata", rdat[m], 0);
                end
            end
            chk("rsp s_rsp_ready", 32'(s_icb_rsp_ready), 32'(!terr && oready));
            if (ev && oready) n_busy = 0;
            else if (!s_icb_rsp_valid) n_waited = waited + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        busy = n_busy; owner = n_owner; prio = n_prio; waited = n_waited;
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle_inputs();
        m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_rsp_ready = 1;
        m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_rsp_ready = 1;
        s_icb_cmd_ready = 1; s_icb_rsp_valid = 0; s_icb_rsp_err = 0;
        s_icb_rsp_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    typedef struct {
        bit v0, v1, sr;
        bit e_sv, e_r0, e_r1;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst = 1;
        busy = 0; owner = 0; prio = 0; waited = 0;
        m0_icb_cmd_addr = 32'hA0; m0_icb_cmd_wdata = 32'h1111_0000; m0_icb_cmd_wmask = 4'h3;
        m1_icb_cmd_addr = 32'hB0; m1_icb_cmd_wdata = 32'h2222_0000; m1_icb_cmd_wmask = 4'hC;
        idle_inputs();
        step();
        do_reset();

        // reset state, nobody requesting
        eval();
        chk("reset s_cmd_valid", 32'(s_icb_cmd_valid), 0);
        chk("reset s_rsp_ready", 32'(s_icb_rsp_ready), 1);
        chk("reset rsp_valid", 32'({m1_icb_rsp_valid, m0_icb_rsp_valid}), 0);
        tick();

        // table: single-cycle pick right after reset (writes, no state change)
        vecs[0] = '{0, 0, 1, 0, 0, 0, 32'h0};
        vecs[1] = '{1, 0, 1, 1, 1, 0, 32'hA0};
        vecs[2] = '{0, 1, 1, 1, 0, 1, 32'hB0};
        vecs[3] = '{1, 1, 1, 1, 1, 0, 32'hA0};
        vecs[4] = '{1, 1, 0, 1, 0, 0, 32'hA0};
        vecs[5] = '{0, 1, 0, 1, 0, 0, 32'hB0};
        foreach (vecs[i]) begin
            do_reset();
            m0_icb_cmd_valid = vecs[i].v0;
            m1_icb_cmd_valid = vecs[i].v1;
            s_icb_cmd_ready  = vecs[i].sr;
            eval();
            chk($sformatf("vec%0d s_cmd_valid", i), 32'(s_icb_cmd_valid), 32'(vecs[i].e_sv));
            chk($sformatf("vec%0d m0_ready", i), 32'(m0_icb_cmd_ready), 32'(vecs[i].e_r0));
            chk($sformatf("vec%0d m1_ready", i), 32'(m1_icb_cmd_ready), 32'(vecs[i].e_r1));
            if (vecs[i].e_sv) chk($sformatf("vec%0d addr", i), s_icb_cmd_addr, vecs[i].e_addr);
            tick();
            idle_inputs();
        end

        // m0 read alone, slave answers after one silent cycle
        do_reset();
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 32'h2000_0010;
        eval();
        chk("rd25 s_addr", s_icb_cmd_addr, 32'h2000_0010);
        tick();
        m0_icb_cmd_valid = 0;
        step();
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hDEAD_BEEF;
        eval();
        chk("rd25 m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
        chk("rd25 m0_rdata", m0_icb_rsp_rdata, 32'hDEAD_BEEF);
        chk("rd25 m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
        tick();
        idle_inputs();
        step();

        // both masters write every cycle: grants alternate starting with m0
        do_reset();
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk($sformatf("alt%0d m0_ready", i), 32'(m0_icb_cmd_ready), 32'(i % 2 == 0));
            chk($sformatf("alt%0d m1_ready", i), 32'(m1_icb_cmd_ready), 32'(i % 2 == 1));
            tick();
        end
        idle_inputs();

        // m1 read outstanding blocks an m0 write until the response is taken
        do_reset();
        m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1;
        step();
        m1_icb_cmd_valid = 0; m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'hA4;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("blk m0_ready", 32'(m0_icb_cmd_ready), 0);
            tick();
        end
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h5A5A_0001;
        eval();
        chk("blk m1_rsp_valid", 32'(m1_icb_rsp_valid), 1);
        chk("blk m0_ready at rsp", 32'(m0_icb_cmd_ready), 0);
        tick();
        s_icb_rsp_valid = 0;
        eval();
        chk("blk m0_ready after", 32'(m0_icb_cmd_ready), 1);
        chk("blk s_addr", s_icb_cmd_addr, 32'hA4);
        tick();
        idle_inputs();

        // timeout: silent slave, error on the 4th RSP cycle, late reply dropped
        do_reset();
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_rsp_ready = 0;
        step();
        m0_icb_cmd_valid = 0;
        for (int i = 1; i <= 3; i++) begin
            eval();
            chk($sformatf("to cyc%0d m0_rsp_valid", i), 32'(m0_icb_rsp_valid), 0);
            tick();
        end
        eval();
        chk("to m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
        chk("to m0_rsp_err", 32'(m0_icb_rsp_err), 1);
        chk("to m0_rdata", m0_icb_rsp_rdata, 0);
        tick();
        m0_icb_rsp_ready = 1;
        step();
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hBAD0_BAD0;
        eval();
        chk("late m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
        chk("late m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
        chk("late s_rsp_ready", 32'(s_icb_rsp_ready), 1);
        tick();
        idle_inputs();

        // reset during RSP abandons the read; m0 wins the next contention
        do_reset();
        m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1;
        step();
        m1_icb_cmd_valid = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h0BAD_0001;
        rst = 1;
        eval();
        chk("rstrsp m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
        tick();
        rst = 0; s_icb_rsp_valid = 0;
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
        eval();
        chk("rstrsp m1_rsp_valid after", 32'(m1_icb_rsp_valid), 0);
        chk("rstrsp m0 wins", 32'(m0_icb_cmd_ready), 1);
        chk("rstrsp m1 loses", 32'(m1_icb_cmd_ready), 0);
        tick();
        idle_inputs();

        // owner back-pressures a held response for 3 cycles
        do_reset();
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1;
        step();
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 1;
        m0_icb_rsp_ready = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("hold m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
            chk("hold m0_rdata", m0_icb_rsp_rdata, 32'h1234_5678);
            chk("hold s_rsp_ready", 32'(s_icb_rsp_ready), 0);
            chk("hold m1_cmd_ready", 32'(m1_icb_cmd_ready), 0);
            tick();
        end
        m0_icb_rsp_ready = 1;
        eval();
        chk("hold release s_rsp_ready", 32'(s_icb_rsp_ready), 1);
        tick();
        s_icb_rsp_valid = 0;
        eval();
        chk("hold m1 granted", 32'(m1_icb_cmd_ready), 1);
        tick();
        idle_inputs();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            m0_icb_cmd_valid = $urandom_range(0, 1); m0_icb_cmd_read = $urandom_range(0, 1);
            m1_icb_cmd_valid = $urandom_range(0, 1); m1_icb_cmd_read = $urandom_range(0, 1);
            m0_icb_cmd_addr = $urandom; m1_icb_cmd_addr = $urandom;
            m0_icb_cmd_wdata = $urandom; m1_icb_cmd_wdata = $urandom;
            m0_icb_cmd_wmask = 4'($urandom); m1_icb_cmd_wmask = 4'($urandom);
            m0_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            s_icb_cmd_ready = ($urandom_range(0, 3) != 0);
            s_icb_rsp_valid = ($urandom_range(0, 4) == 0);
            s_icb_rsp_err = $urandom_range(0, 1);
            s_icb_rsp_rdata = $urandom;
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
